// File: rtl/vc_fifo_bank.sv
// vc_fifo_bank: NUM_VC independent circular FIFOs (virtual channels) sharing one write
// port and one read port. Provides per-VC occupancy/status, a per-VC credit pulse on
// every delivered flit, and one-cycle error pulses for rejected writes and reads.
// Note: rst_n is an asynchronous reset that is asserted HIGH.
module vc_fifo_bank #(
  parameter int NUM_BITS  = 8,
  parameter int DEPTH     = 8,
  parameter int NUM_VC    = 4,
  parameter int AF_THRESH = 6,
  localparam int VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int CW  = $clog2(DEPTH) + 1,
  localparam int PW  = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [VCW-1:0]         wr_vc,
  input  logic [NUM_BITS-1:0]    fifo_in,
  input  logic                   rd_en,
  input  logic [VCW-1:0]         rd_vc,
  output logic [NUM_BITS-1:0]    fifo_out,
  output logic                   out_valid,
  output logic [VCW-1:0]         out_vc,
  output logic [NUM_VC-1:0]      empty,
  output logic [NUM_VC-1:0]      full,
  output logic [NUM_VC-1:0]      almost_full,
  output logic [NUM_VC*CW-1:0]   fifo_counter,
  output logic [NUM_VC-1:0]      credit_ret,
  output logic                   wr_drop,
  output logic                   rd_err
);

  logic [CW-1:0]       cnt_q    [NUM_VC];
  logic [CW-1:0]       cnt_d    [NUM_VC];
  logic [PW-1:0]       wr_ptr_q [NUM_VC];
  logic [PW-1:0]       wr_ptr_d [NUM_VC];
  logic [PW-1:0]       rd_ptr_q [NUM_VC];
  logic [PW-1:0]       rd_ptr_d [NUM_VC];
  logic [NUM_BITS-1:0] mem_q    [NUM_VC][DEPTH];

  logic [NUM_BITS-1:0] fifo_out_q, fifo_out_d;
  logic                out_valid_q, out_valid_d;
  logic [VCW-1:0]      out_vc_q, out_vc_d;
  logic [NUM_VC-1:0]   credit_ret_q, credit_ret_d;
  logic                wr_drop_q, wr_drop_d;
  logic                rd_err_q, rd_err_d;

  logic                wr_vc_ok, rd_vc_ok;
  logic [VCW-1:0]      wr_idx, rd_idx;
  logic                wr_acc, rd_acc;

  // An index beyond NUM_VC only exists when NUM_VC is not a power of two; such a VC
  // behaves as both full and empty so every access to it is rejected.
  if (NUM_VC == (1 << VCW)) begin : g_vc_pow2
    assign wr_vc_ok = 1'b1;
    assign rd_vc_ok = 1'b1;
  end else begin : g_vc_npow2
    assign wr_vc_ok = (int'(wr_vc) < NUM_VC);
    assign rd_vc_ok = (int'(rd_vc) < NUM_VC);
  end

  // Per-VC status decoded straight from the occupancy counters.
  always_comb begin
    empty        = '0;
    full         = '0;
    almost_full  = '0;
    fifo_counter = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      empty[i]                  = (cnt_q[i] == '0);
      full[i]                   = (cnt_q[i] == CW'(DEPTH));
      almost_full[i]            = (cnt_q[i] >= CW'(AF_THRESH));
      fifo_counter[i*CW +: CW]  = cnt_q[i];
    end
  end

  // Accept/reject decision using pre-edge status; same-VC write and read never bypass.
  always_comb begin
    wr_idx = wr_vc_ok ? wr_vc : '0;
    rd_idx = rd_vc_ok ? rd_vc : '0;
    wr_acc = wr_en && wr_vc_ok && !full[wr_idx];
    rd_acc = rd_en && rd_vc_ok && !empty[rd_idx];
  end

  // Next-state for pointers and counters; simultaneous push/pop on one VC cancels out.
  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
    end
    if (wr_acc) wr_ptr_d[wr_idx] = wr_ptr_q[wr_idx] + PW'(1);
    if (rd_acc) rd_ptr_d[rd_idx] = rd_ptr_q[rd_idx] + PW'(1);
    for (int i = 0; i < NUM_VC; i++) begin
      case ({wr_acc && (wr_idx == VCW'(i)), rd_acc && (rd_idx == VCW'(i))})
        2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // Next-state for the registered read port and the one-cycle pulses.
  always_comb begin
    fifo_out_d   = rd_acc ? mem_q[rd_idx][rd_ptr_q[rd_idx]] : fifo_out_q;
    out_valid_d  = rd_acc;
    out_vc_d     = rd_acc ? rd_idx : out_vc_q;
    credit_ret_d = '0;
    if (rd_acc) credit_ret_d[rd_idx] = 1'b1;
    wr_drop_d    = wr_en && !wr_acc;
    rd_err_d     = rd_en && !rd_acc;
  end

  // Control state; reset discards all queued flits immediately.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_VC; i++) begin
        cnt_q[i]    <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      fifo_out_q   <= '0;
      out_valid_q  <= 1'b0;
      out_vc_q     <= '0;
      credit_ret_q <= '0;
      wr_drop_q    <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        cnt_q[i]    <= cnt_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
      fifo_out_q   <= fifo_out_d;
      out_valid_q  <= out_valid_d;
      out_vc_q     <= out_vc_d;
      credit_ret_q <= credit_ret_d;
      wr_drop_q    <= wr_drop_d;
      rd_err_q     <= rd_err_d;
    end
  end

  // Flit storage is left unreset; only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_idx][wr_ptr_q[wr_idx]] <= fifo_in;
  end

  assign fifo_out   = fifo_out_q;
  assign out_valid  = out_valid_q;
  assign out_vc     = out_vc_q;
  assign credit_ret = credit_ret_q;
  assign wr_drop    = wr_drop_q;
  assign rd_err     = rd_err_q;

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Bench for vc_fifo_bank: per-VC queue model plus a scoreboard of expected read results.
module tb_vc_fifo_bank;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  wr_vc;
  logic [7:0]  fifo_in;
  logic        rd_en;
  logic [1:0]  rd_vc;
  logic [7:0]  fifo_out;
  logic        out_valid;
  logic [1:0]  out_vc;
  logic [3:0]  empty;
  logic [3:0]  full;
  logic [3:0]  almost_full;
  logic [15:0] fifo_counter;
  logic [3:0]  credit_ret;
  logic        wr_drop;
  logic        rd_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq [4][$];
  logic [9:0] exp_q [$];
  logic       exp_valid, exp_wr_drop, exp_rd_err;
  logic [3:0] exp_credit;
  logic [9:0] exp;

  vc_fifo_bank dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_vc(wr_vc), .fifo_in(fifo_in),
    .rd_en(rd_en), .rd_vc(rd_vc),
    .fifo_out(fifo_out), .out_valid(out_valid), .out_vc(out_vc),
    .empty(empty), .full(full), .almost_full(almost_full),
    .fifo_counter(fifo_counter), .credit_ret(credit_ret),
    .wr_drop(wr_drop), .rd_err(rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] cnt(input int v);
    return fifo_counter[v*4 +: 4];
  endfunction

  // Drive one cycle of stimulus, update the model, leave time at posedge+1.
  task automatic step(input logic we, input logic [1:0] wv, input logic [7:0] d,
                      input logic re, input logic [1:0] rv);
    bit fp, ep, ra, wa;
    fp = (mq[wv].size() == 8);
    ep = (mq[rv].size() == 0);
    ra = re && !ep;
    wa = we && !fp;
    exp_valid   = ra;
    exp_wr_drop = we && fp;
    exp_rd_err  = re && ep;
    exp_credit  = ra ? (4'b0001 << rv) : 4'b0000;
    if (ra) exp_q.push_back({rv, mq[rv].pop_front()});
    if (wa) mq[wv].push_back(d);
    wr_en = we; wr_vc = wv; fifo_in = d; rd_en = re; rd_vc = rv;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    wr_en = 0; wr_vc = 0; fifo_in = 0; rd_en = 0; rd_vc = 0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) mq[i].delete();
    exp_q.delete();
    total++; if (empty !== 4'hF) begin bad++; $display("FAIL reset_empty got=%h exp=f", empty); end
    total++; if (full !== 4'h0 || almost_full !== 4'h0) begin bad++; $display("FAIL reset_full got=%h/%h exp=0/0", full, almost_full); end
    total++; if (fifo_counter !== 16'h0) begin bad++; $display("FAIL reset_counter got=%h exp=0", fifo_counter); end
    total++; if ({out_valid, fifo_out, out_vc, credit_ret, wr_drop, rd_err} !== 17'h0)
      begin bad++; $display("FAIL reset_outputs got=%b/%h/%0d/%b/%b/%b exp=0", out_valid, fifo_out, out_vc, credit_ret, wr_drop, rd_err); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 8'(8'hA0 + k), 0, 0);
      total++; if (cnt(0) !== 4'(k + 1)) begin bad++; $display("FAIL fill_cnt k=%0d got=%0d exp=%0d", k, cnt(0), k + 1); end
      total++; if (almost_full[0] !== (k + 1 >= 6)) begin bad++; $display("FAIL fill_af k=%0d got=%b exp=%b", k, almost_full[0], (k + 1 >= 6)); end
      total++; if (full[0] !== (k == 7)) begin bad++; $display("FAIL fill_full k=%0d got=%b exp=%b", k, full[0], (k == 7)); end
      total++; if (wr_drop !== 1'b0) begin bad++; $display("FAIL fill_nodrop k=%0d got=%b exp=0", k, wr_drop); end
    end
    step(1, 0, 8'hA8, 0, 0);
    total++; if (wr_drop !== 1'b1) begin bad++; $display("FAIL fill_drop got=%b exp=1", wr_drop); end
    total++; if (cnt(0) !== 4'd8) begin bad++; $display("FAIL fill_drop_cnt got=%0d exp=8", cnt(0)); end
    step(0, 0, 0, 0, 0);
    total++; if (wr_drop !== 1'b0) begin bad++; $display("FAIL fill_drop_pulse got=%b exp=0", wr_drop); end
  endtask

  task automatic test_two_vc();
    step(1, 1, 8'h11, 0, 0);
    step(1, 2, 8'h22, 0, 0);
    step(0, 0, 0, 1, 2);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL two_vc_valid2 got=%b exp=1", out_valid); end
    exp = exp_q.pop_front();
    total++; if ({out_vc, fifo_out} !== exp || fifo_out !== 8'h22) begin bad++; $display("FAIL two_vc_data2 got=%0d/%h exp=%0d/%h", out_vc, fifo_out, exp[9:8], exp[7:0]); end
    total++; if (credit_ret !== 4'b0100) begin bad++; $display("FAIL two_vc_credit2 got=%b exp=0100", credit_ret); end
    step(0, 0, 0, 1, 1);
    exp = exp_q.pop_front();
    total++; if ({out_vc, fifo_out} !== exp || fifo_out !== 8'h11) begin bad++; $display("FAIL two_vc_data1 got=%0d/%h exp=%0d/%h", out_vc, fifo_out, exp[9:8], exp[7:0]); end
    total++; if (credit_ret !== 4'b0010) begin bad++; $display("FAIL two_vc_credit1 got=%b exp=0010", credit_ret); end
    step(0, 0, 0, 0, 0);
    total++; if (out_valid !== 1'b0 || credit_ret !== 4'b0) begin bad++; $display("FAIL two_vc_idle got=%b/%b exp=0/0000", out_valid, credit_ret); end
    total++; if (fifo_out !== 8'h11 || out_vc !== 2'd1) begin bad++; $display("FAIL two_vc_hold got=%h/%0d exp=11/1", fifo_out, out_vc); end
  endtask

  task automatic test_full_rw();
    for (int k = 0; k < 8; k++) step(1, 3, 8'(8'h30 + k), 0, 0);
    total++; if (full[3] !== 1'b1) begin bad++; $display("FAIL full_rw_full got=%b exp=1", full[3]); end
    step(1, 3, 8'hEE, 1, 3);
    exp = exp_q.pop_front();
    total++; if (out_valid !== 1'b1 || {out_vc, fifo_out} !== exp) begin bad++; $display("FAIL full_rw_pop got=%b/%0d/%h exp=1/%0d/%h", out_valid, out_vc, fifo_out, exp[9:8], exp[7:0]); end
    total++; if (wr_drop !== 1'b1) begin bad++; $display("FAIL full_rw_drop got=%b exp=1", wr_drop); end
    total++; if (cnt(3) !== 4'd7) begin bad++; $display("FAIL full_rw_cnt got=%0d exp=7", cnt(3)); end
    while (mq[3].size() > 0) begin
      step(0, 0, 0, 1, 3);
      exp = exp_q.pop_front();
      total++; if (out_valid !== 1'b1 || {out_vc, fifo_out} !== exp) begin bad++; $display("FAIL full_rw_drain got=%b/%0d/%h exp=1/%0d/%h", out_valid, out_vc, fifo_out, exp[9:8], exp[7:0]); end
    end
    step(0, 0, 0, 1, 3);
    total++; if (rd_err !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL full_rw_underflow got=%b/%b exp=1/0", rd_err, out_valid); end
  endtask

  task automatic test_empty_rw();
    while (mq[0].size() > 0) begin
      step(0, 0, 0, 1, 0);
      exp = exp_q.pop_front();
      total++; if (out_valid !== 1'b1 || {out_vc, fifo_out} !== exp) begin bad++; $display("FAIL empty_rw_drain got=%b/%0d/%h exp=1/%0d/%h", out_valid, out_vc, fifo_out, exp[9:8], exp[7:0]); end
    end
    step(1, 0, 8'h5A, 1, 0);
    total++; if (rd_err !== exp_rd_err || rd_err !== 1'b1) begin bad++; $display("FAIL empty_rw_err got=%b exp=1", rd_err); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL empty_rw_valid got=%b exp=0", out_valid); end
    total++; if (cnt(0) !== 4'd1) begin bad++; $display("FAIL empty_rw_cnt got=%0d exp=1", cnt(0)); end
    step(0, 0, 0, 1, 0);
    exp = exp_q.pop_front();
    total++; if (out_valid !== 1'b1 || {out_vc, fifo_out} !== exp || fifo_out !== 8'h5A) begin bad++; $display("FAIL empty_rw_read got=%b/%h exp=1/5a", out_valid, fifo_out); end
    total++; if (rd_err !== 1'b0) begin bad++; $display("FAIL empty_rw_noerr got=%b exp=0", rd_err); end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 3; k++) step(1, 0, 8'(8'h70 + k), 0, 0);
    for (int k = 0; k < 20; k++) begin
      step(1, 0, 8'(8'h80 + k), 1, 0);
      exp = exp_q.pop_front();
      total++; if (out_valid !== 1'b1 || {out_vc, fifo_out} !== exp) begin bad++; $display("FAIL wrap_data k=%0d got=%b/%h exp=1/%h", k, out_valid, fifo_out, exp[7:0]); end
      total++; if (cnt(0) !== 4'd3 || wr_drop !== 1'b0 || rd_err !== 1'b0) begin bad++; $display("FAIL wrap_cnt k=%0d got=%0d/%b/%b exp=3/0/0", k, cnt(0), wr_drop, rd_err); end
    end
    while (mq[0].size() > 0) begin
      step(0, 0, 0, 1, 0);
      exp = exp_q.pop_front();
      total++; if (out_valid !== 1'b1 || {out_vc, fifo_out} !== exp) begin bad++; $display("FAIL wrap_drain got=%b/%h exp=1/%h", out_valid, fifo_out, exp[7:0]); end
    end
    total++; if (empty !== 4'hF) begin bad++; $display("FAIL wrap_empty got=%h exp=f", empty); end
  endtask

  task automatic test_async_reset();
    step(1, 1, 8'h91, 0, 0);
    step(1, 1, 8'h92, 0, 0);
    step(1, 2, 8'hA1, 0, 0);
    step(1, 2, 8'hA2, 1, 1);
    exp = exp_q.pop_front();
    total++; if (out_valid !== 1'b1 || {out_vc, fifo_out} !== exp) begin bad++; $display("FAIL areset_pre got=%b/%h exp=1/%h", out_valid, fifo_out, exp[7:0]); end
    #2;
    rst_n = 1'b1;
    #1;
    total++; if ({out_valid, fifo_out, out_vc, credit_ret} !== 15'h0) begin bad++; $display("FAIL areset_outputs got=%b/%h/%0d/%b exp=0", out_valid, fifo_out, out_vc, credit_ret); end
    total++; if (empty !== 4'hF || fifo_counter !== 16'h0) begin bad++; $display("FAIL areset_status got=%h/%h exp=f/0", empty, fifo_counter); end
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) mq[i].delete();
    exp_q.delete();
    step(0, 0, 0, 1, 1);
    total++; if (rd_err !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL areset_rd_err got=%b/%b exp=1/0", rd_err, out_valid); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_two_vc();
    test_full_rw();
    test_empty_rw();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
